pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register carrying a data payload and a control bundle between two pipeline stages, with a valid/ready handshake. Intended as the common building block for every inter-stage register in the core (F/D, D/E, E/M, M/W). Flush squashes the control bundle to a bubble and leaves the data payload untouched. An optional 2-entry skid buffer breaks the combinational ready path between stages.

---
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, shared by every
// inter-stage boundary (F/D, D/E, E/M, M/W). Flush turns the control bundle
// into a bubble and leaves the data payload as it is.
// Build option: define PIPE_STAGE_SKID_EN to add a 2-entry skid buffer
// with a registered in_ready. Without it, the stage is a single register
// with combinational in_ready.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W   = 96,
    parameter int unsigned       CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic accept;
    logic pop;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // Main/skid occupancy control; in_ready is low exactly while the skid entry is full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= CTRL_RST;
            skid_data <= '0;
            skid_ctrl <= CTRL_RST;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_RST;
            skid_ctrl <= CTRL_RST;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        out_ctrl  <= in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        out_data <= in_data;
                        out_ctrl <= in_ctrl;
                    end else if (accept) begin
                        state     <= TWO;
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        in_ready  <= 1'b0;
                    end else if (pop) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        out_ctrl  <= CTRL_RST;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state     <= ONE;
                        out_data  <= skid_data;
                        out_ctrl  <= skid_ctrl;
                        skid_ctrl <= CTRL_RST;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean empty stage
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    out_ctrl  <= CTRL_RST;
                    skid_ctrl <= CTRL_RST;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`else

    // Single-entry stage: a pop frees the slot in the same cycle
    assign in_ready = !out_valid | out_ready;

    // Main register load, bubble insertion on pop-without-refill, and flush squash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= CTRL_RST;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_RST;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_ctrl  <= in_ctrl;
        end else if (pop) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_RST;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. The reference model is a FIFO queue
// of beats with a capacity limit, plus the last payload left in the main register.
// It follows the PIPE_STAGE_SKID_EN define of the RTL.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 96;
    localparam int unsigned CW = 16;
    localparam int unsigned VW = DW + CW + 2;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID  = 1'b1;
    localparam int DEPTH = 2;
`else
    localparam bit SKID  = 1'b0;
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;

    int errors = 0;
    int checks = 0;

    beat_t         q[$];
    logic [DW-1:0] last_data;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W  (DW),
        .CTRL_W  (CW),
        .CTRL_RST({CW{1'b0}})
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl)
    );

    function automatic logic exp_ready();
        return (q.size() < DEPTH) || (!SKID && out_ready);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        if (q.size() != 0) return {1'b1, q[0].c, q[0].d, exp_ready()};
        return {1'b0, {CW{1'b0}}, last_data, exp_ready()};
    endfunction

    // Drive one cycle of stimulus and advance the model across the clock edge
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl, output logic acc);
        logic rdy;
        logic pp;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        rdy = exp_ready();
        pp  = (q.size() != 0) && ordy;
        acc = v && rdy && !fl;
        @(posedge clk);
        if (fl) begin
            if (q.size() != 0) last_data = q[0].d;
            q.delete();
        end else begin
            if (pp) begin
                last_data = q[0].d;
                void'(q.pop_front());
            end
            if (acc) q.push_back({d, c});
        end
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_reset();
        logic acc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        q.delete();
        last_data = '0;
        #12;
        rst = 1'b0;
        checks++;
        if ({out_valid, out_ctrl, out_data, in_ready} !== {1'b0, 16'h0, 96'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_init: got v=%0b c=%h d=%h r=%0b, want v=0 c=0 d=0 r=1",
                     out_valid, out_ctrl, out_data, in_ready);
        end
        cycle(1'b1, 96'hDEAD_BEEF, 16'h00A5, 1'b0, 1'b0, acc);
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h00A5) begin
            errors++;
            $display("FAIL reset_preload: got v=%0b c=%h, want v=1 c=00a5", out_valid, out_ctrl);
        end
        #3;
        rst = 1'b1;
        q.delete();
        last_data = '0;
        #1;
        checks++;
        if ({out_valid, out_ctrl, out_data, in_ready} !== {1'b0, 16'h0, 96'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async: got v=%0b c=%h d=%h r=%0b, want v=0 c=0 d=0 r=1",
                     out_valid, out_ctrl, out_data, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        logic acc;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, DW'(i), 16'h0011, 1'b1, 1'b0, acc);
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== 16'h0011
                || {out_valid, out_ctrl, out_data, in_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL stream[%0d]: got v=%0b c=%h d=%h r=%0b, want d=%0d c=0011 model=%h",
                         i, out_valid, out_ctrl, out_data, in_ready, i, exp_vec());
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic          acc;
        logic [DW-1:0] beats[3];
        logic [DW-1:0] got[$];
        int            idx;
        int            budget;
        beats[0] = 96'h1; beats[1] = 96'h2; beats[2] = 96'h3;
        idx = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, beats[idx], 16'h0022, 1'b0, 1'b0, acc);
            if (acc) idx++;
            checks++;
            if ({out_valid, out_ctrl, out_data, in_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL bp_fill[%0d]: got v=%0b c=%h d=%h r=%0b, want %h",
                         k, out_valid, out_ctrl, out_data, in_ready, exp_vec());
            end
            if (k == 0) begin
                checks++;
                if (in_ready !== SKID) begin
                    errors++;
                    $display("FAIL bp_ready_after_a: got %0b want %0b", in_ready, SKID);
                end
            end
        end
        checks++;
        if (in_ready !== 1'b0 || idx != DEPTH) begin
            errors++;
            $display("FAIL bp_stall: got r=%0b accepted=%0d, want r=0 accepted=%0d",
                     in_ready, idx, DEPTH);
        end
        budget = 0;
        while (got.size() < 3 && budget < 20) begin
            if (out_valid === 1'b1) got.push_back(out_data);
            if (idx < 3) cycle(1'b1, beats[idx], 16'h0022, 1'b1, 1'b0, acc);
            else cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
            if (acc) idx++;
            budget++;
            checks++;
            if ({out_valid, out_ctrl, out_data, in_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got v=%0b c=%h d=%h r=%0b, want %h",
                         budget, out_valid, out_ctrl, out_data, in_ready, exp_vec());
            end
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_timeout: got %0d beats want 3", got.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (got[j] !== beats[j]) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h want %h", j, got[j], beats[j]);
                end
            end
        end
        drain();
    endtask

    task automatic test_flush();
        logic acc;
        cycle(1'b1, 96'hA2, 16'h0033, 1'b0, 1'b0, acc);
        cycle(1'b1, 96'hB2, 16'h0044, 1'b0, 1'b0, acc);
        cycle(1'b1, 96'hD0, 16'h1234, 1'b0, 1'b1, acc);
        checks++;
        if ({out_valid, out_ctrl, out_data, in_ready} !== {1'b0, 16'h0, 96'hA2, 1'b1}) begin
            errors++;
            $display("FAIL flush: got v=%0b c=%h d=%h r=%0b, want v=0 c=0 d=a2 r=1",
                     out_valid, out_ctrl, out_data, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
            checks++;
            if (out_valid !== 1'b0 || {out_valid, out_ctrl, out_data, in_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL flush_after[%0d]: got v=%0b c=%h d=%h, want %h",
                         k, out_valid, out_ctrl, out_data, exp_vec());
            end
        end
    endtask

    task automatic test_pop_no_refill();
        logic acc;
        cycle(1'b1, 96'h5555_0000_0F0F, 16'h0F0F, 1'b0, 1'b0, acc);
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h0F0F) begin
            errors++;
            $display("FAIL bubble_load: got v=%0b c=%h, want v=1 c=0f0f", out_valid, out_ctrl);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
        checks++;
        if ({out_valid, out_ctrl, out_data} !== {1'b0, 16'h0, 96'h5555_0000_0F0F}) begin
            errors++;
            $display("FAIL bubble: got v=%0b c=%h d=%h, want v=0 c=0 d=555500000f0f",
                     out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_simul_pop_accept();
        logic acc;
        cycle(1'b1, 96'hAAAA, 16'h0101, 1'b0, 1'b0, acc);
        cycle(1'b1, 96'hBBBB, 16'h0202, 1'b1, 1'b0, acc);
        checks++;
        if ({out_valid, out_ctrl, out_data, in_ready} !== {1'b1, 16'h0202, 96'hBBBB, 1'b1}) begin
            errors++;
            $display("FAIL pop_accept: got v=%0b c=%h d=%h r=%0b, want v=1 c=0202 d=bbbb r=1",
                     out_valid, out_ctrl, out_data, in_ready);
        end
        drain();
    endtask

    task automatic test_random();
        logic          acc;
        logic          v;
        logic          ordy;
        logic          fl;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        for (int k = 0; k < 400; k++) begin
            v    = 1'($urandom_range(0, 3) != 0);
            ordy = 1'($urandom_range(0, 2) != 0);
            fl   = 1'($urandom_range(0, 24) == 0);
            d    = {$urandom(), $urandom(), $urandom()};
            c    = CW'($urandom());
            cycle(v, d, c, ordy, fl, acc);
            checks++;
            if ({out_valid, out_ctrl, out_data, in_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got v=%0b c=%h d=%h r=%0b, want %h",
                         k, out_valid, out_ctrl, out_data, in_ready, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_pop_no_refill();
        test_simul_pop_accept();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
